// File: rtl/fir_tap_loader_pkg.sv
// Shared types and constants for the FIR coefficient loader.
package fir_tap_pkg;

  typedef enum logic [2:0] {
    LD_IDLE,
    LD_FLUSH,
    LD_ARM,
    LD_STREAM,
    LD_WAIT_DONE
  } loader_state_t;

  localparam int unsigned FLUSH_CYCLES = 2;

endpackage

// File: rtl/fir_tap_loader_if.sv
// Tap stream from the loader to the FIR tap_din port (valid/ready, AXI-S style).
interface fir_tap_loader_if #(
  parameter int G_TAP_WIDTH = 16
);
  logic [G_TAP_WIDTH-1:0] tap_dout;
  logic                   tap_dout_valid;
  logic                   tap_dout_ready;

  modport master (
    output tap_dout,
    output tap_dout_valid,
    input  tap_dout_ready
  );

  modport slave (
    input  tap_dout,
    input  tap_dout_valid,
    output tap_dout_ready
  );
endinterface

// File: rtl/fir_tap_loader_ram.sv
// Simple dual-port tap RAM, 1-cycle registered read; only the read register is reset.
// The read register holds its value while rd_en is low, so it doubles as the stream prefetch stage.
module fir_tap_ram #(
  parameter int G_ADDR_WIDTH = 4,
  parameter int G_DATA_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [G_ADDR_WIDTH-1:0] wr_addr,
  input  logic [G_DATA_WIDTH-1:0] wr_data,
  input  logic                    rd_en,
  input  logic [G_ADDR_WIDTH-1:0] rd_addr,
  output logic [G_DATA_WIDTH-1:0] rd_data
);

  logic [G_DATA_WIDTH-1:0] mem_q [0:(2**G_ADDR_WIDTH)-1];
  logic [G_DATA_WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fir_tap_loader.sv
// FIR tap loader: restarts the FIR, streams 2**G_NUM_TAPS_LOG2 taps, waits for sample mode.
// Latency load_start -> first valid 4 cycles; 1 tap/cycle, stalls losslessly on tap_dout_ready low.
// FIR_TAP_SYMMETRIC_EN: store half the table and stream it mirrored (linear-phase).
module fir_tap_loader
  import fir_tap_pkg::*;
#(
  parameter int G_NUM_TAPS_LOG2 = 4,
  parameter int G_TAP_WIDTH     = 16,
  parameter int G_DONE_TIMEOUT  = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [G_NUM_TAPS_LOG2-1:0] cfg_wr_addr,
  input  logic [G_TAP_WIDTH-1:0]     cfg_wr_data,
  input  logic                       cfg_wr_valid,
  output logic                       cfg_wr_ready,
  input  logic                       load_start,
  output logic                       busy,
  output logic                       load_done,
  output logic                       load_error,
  output logic                       fir_enable,
  fir_tap_loader_if.master           tap_if,
  input  logic                       fir_ready_in
);

  localparam int NUM_TAPS = 2**G_NUM_TAPS_LOG2;
  localparam int IDX_W    = G_NUM_TAPS_LOG2 + 1;
  localparam int TMR_W    = $clog2(G_DONE_TIMEOUT + 1);
`ifdef FIR_TAP_SYMMETRIC_EN
  localparam int RAM_AW   = G_NUM_TAPS_LOG2 - 1;
  localparam logic [IDX_W-1:0] HALF_IDX = IDX_W'(NUM_TAPS / 2);
`else
  localparam int RAM_AW   = G_NUM_TAPS_LOG2;
`endif
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_TAPS - 1);
  localparam logic [TMR_W-1:0] TMR_MAX  = TMR_W'(G_DONE_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(G_DONE_TIMEOUT - 1);
  localparam logic [1:0]       FL_LAST  = 2'(FLUSH_CYCLES - 1);

  loader_state_t     state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TMR_W-1:0]  tmr_q, tmr_d;
  logic [1:0]        flush_cnt_q, flush_cnt_d;
  logic              fir_en_q, fir_en_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cfg_rdy_q;

  logic              accept;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_idx;
  logic [RAM_AW-1:0] rd_addr;
  logic              wr_en;
  logic [G_TAP_WIDTH-1:0] ram_rd_data;

  function automatic logic [RAM_AW-1:0] map_addr(input logic [IDX_W-1:0] k);
    logic [IDX_W-1:0] m;
`ifdef FIR_TAP_SYMMETRIC_EN
    m = (k < HALF_IDX) ? k : (LAST_IDX - k);
`else
    m = k;
`endif
    return m[RAM_AW-1:0];
  endfunction

  // Upper-half writes have no storage when the table is mirrored.
`ifdef FIR_TAP_SYMMETRIC_EN
  assign wr_en = cfg_wr_valid & cfg_rdy_q & ~cfg_wr_addr[G_NUM_TAPS_LOG2-1];
`else
  assign wr_en = cfg_wr_valid & cfg_rdy_q;
`endif

  assign accept  = valid_q & tap_if.tap_dout_ready;
  assign rd_addr = map_addr(rd_idx);

  fir_tap_ram #(
    .G_ADDR_WIDTH (RAM_AW),
    .G_DATA_WIDTH (G_TAP_WIDTH)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (cfg_wr_addr[RAM_AW-1:0]),
    .wr_data (cfg_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    flush_cnt_d = flush_cnt_q;
    fir_en_d    = fir_en_q;
    valid_d     = valid_q;
    done_d      = 1'b0;
    err_d       = err_q;
    rd_en       = 1'b0;
    rd_idx      = idx_q;

    case (state_q)
      LD_IDLE: begin
        if (load_start) begin
          state_d     = LD_FLUSH;
          fir_en_d    = 1'b0;
          err_d       = 1'b0;
          flush_cnt_d = '0;
        end
      end
      LD_FLUSH: begin
        if (flush_cnt_q == FL_LAST) begin
          state_d  = LD_ARM;
          fir_en_d = 1'b1;
        end else begin
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end
      LD_ARM: begin
        rd_en   = 1'b1;
        rd_idx  = '0;
        idx_d   = '0;
        valid_d = 1'b1;
        state_d = LD_STREAM;
      end
      LD_STREAM: begin
        // The next read is only issued on acceptance, so the RAM register holds the beat while stalled.
        if (accept) begin
          if (idx_q == LAST_IDX) begin
            valid_d = 1'b0;
            tmr_d   = '0;
            state_d = LD_WAIT_DONE;
          end else begin
            idx_d  = idx_q + 1'b1;
            rd_idx = idx_q + 1'b1;
            rd_en  = 1'b1;
          end
        end
      end
      LD_WAIT_DONE: begin
        if (fir_ready_in) begin
          done_d  = 1'b1;
          state_d = LD_IDLE;
        end else begin
          tmr_d = (tmr_q == TMR_MAX) ? tmr_q : tmr_q + 1'b1;
          if (tmr_q >= TMR_LAST) begin
            err_d   = 1'b1;
            state_d = LD_IDLE;
          end
        end
      end
      default: state_d = LD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= LD_IDLE;
      idx_q       <= '0;
      tmr_q       <= '0;
      flush_cnt_q <= '0;
      fir_en_q    <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_rdy_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      flush_cnt_q <= flush_cnt_d;
      fir_en_q    <= fir_en_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cfg_rdy_q   <= (state_d == LD_IDLE);
    end
  end

  assign cfg_wr_ready          = cfg_rdy_q;
  assign busy                  = (state_q != LD_IDLE);
  assign load_done             = done_q;
  assign load_error            = err_q;
  assign fir_enable            = fir_en_q;
  assign tap_if.tap_dout       = ram_rd_data;
  assign tap_if.tap_dout_valid = valid_q;

endmodule

// File: tb/tb_fir_tap_loader.sv
// Directed bench for fir_tap_loader: tap-table model, per-beat scoreboard, latency/timeout/abort checks.
`timescale 1ns/1ps
module tb_fir_tap_loader;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;
  localparam int T  = 2**N;
`ifdef FIR_TAP_SYMMETRIC_EN
  localparam int LAST_TAP = 1;
  localparam int MID_TAP  = 8;
`else
  localparam int LAST_TAP = 16;
  localparam int MID_TAP  = 9;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] cfg_wr_addr;
  logic [W-1:0] cfg_wr_data;
  logic         cfg_wr_valid;
  logic         cfg_wr_ready;
  logic         load_start;
  logic         busy;
  logic         load_done;
  logic         load_error;
  logic         fir_enable;
  logic         fir_ready_in;

  always #5 clk = ~clk;

  fir_tap_loader_if #(.G_TAP_WIDTH(W)) tap_if ();

  fir_tap_loader #(
    .G_NUM_TAPS_LOG2 (N),
    .G_TAP_WIDTH     (W),
    .G_DONE_TIMEOUT  (TO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_wr_addr  (cfg_wr_addr),
    .cfg_wr_data  (cfg_wr_data),
    .cfg_wr_valid (cfg_wr_valid),
    .cfg_wr_ready (cfg_wr_ready),
    .load_start   (load_start),
    .busy         (busy),
    .load_done    (load_done),
    .load_error   (load_error),
    .fir_enable   (fir_enable),
    .tap_if       (tap_if),
    .fir_ready_in (fir_ready_in)
  );

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] model_mem [T];
  logic [W-1:0] exp_q [$];
  int           beats;
  bit           chk_en = 1'b0;
  bit           hold_flag = 1'b0;
  logic [W-1:0] hold_dat;
  logic [W-1:0] first_dat;
  logic [W-1:0] last_dat;
  logic [15:0]  pat = 16'b1001_1001_0110_1001;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Tap index -> table address, straight from the mirror rule.
  function automatic int tap_addr(input int k);
`ifdef FIR_TAP_SYMMETRIC_EN
    return (k < T/2) ? k : T - 1 - k;
`else
    return k;
`endif
  endfunction

  task automatic model_write(input int a, input int d);
`ifdef FIR_TAP_SYMMETRIC_EN
    if (a < T/2) model_mem[a] = W'(d);
`else
    model_mem[a] = W'(d);
`endif
  endtask

  task automatic build_exp();
    exp_q.delete();
    for (int k = 0; k < T; k++) exp_q.push_back(model_mem[tap_addr(k)]);
  endtask

  task automatic cfg_write(input int a, input int d);
    @(posedge clk); #1;
    cfg_wr_addr  = N'(a);
    cfg_wr_data  = W'(d);
    cfg_wr_valid = 1'b1;
    @(posedge clk); #1;
    cfg_wr_valid = 1'b0;
    model_write(a, d);
  endtask

  // Scoreboard: every accepted beat against the model, stalled beats must hold.
  always @(negedge clk) begin
    if (!chk_en) begin
      hold_flag = 1'b0;
    end else begin
      if (hold_flag) begin
        chk("stall_valid_held", 32'(tap_if.tap_dout_valid), 32'd1);
        chk("stall_data_held", 32'(tap_if.tap_dout), 32'(hold_dat));
      end
      hold_flag = 1'b0;
      if (tap_if.tap_dout_valid && tap_if.tap_dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_beat", 32'(beats + 1), 32'(T));
        end else begin
          if (beats == 0) first_dat = tap_if.tap_dout;
          last_dat = tap_if.tap_dout;
          chk($sformatf("beat%0d_data", beats), 32'(tap_if.tap_dout), 32'(exp_q.pop_front()));
          beats++;
        end
      end else if (tap_if.tap_dout_valid) begin
        hold_flag = 1'b1;
        hold_dat  = tap_if.tap_dout;
      end
    end
  end

  // rdy_mode 0: ready always high, 1: patterned stalls. rdy_after<0: FIR never reports ready.
  task automatic run_load(input int rdy_mode, input int rdy_after, input int abort_at,
                          input bit mid_wr, input bit wr_same);
    int lat;
    int cyc;
    int n;
    int exp_n;
    bit exp_done;
    bit wr_issued;
    bit seen_done;
    if (wr_same) model_write(0, 16'h1234);
    build_exp();
    beats  = 0;
    chk_en = 1'b1;
    @(posedge clk); #1;
    load_start            = 1'b1;
    tap_if.tap_dout_ready = (rdy_mode == 1) ? pat[0] : 1'b1;
    if (wr_same) begin
      cfg_wr_addr  = '0;
      cfg_wr_data  = 16'h1234;
      cfg_wr_valid = 1'b1;
    end
    @(posedge clk); #1;
    load_start   = 1'b0;
    cfg_wr_valid = 1'b0;
    lat = 1;
    chk("flush_busy", 32'(busy), 32'd1);
    chk("flush_enable_low", 32'(fir_enable), 32'd0);
    chk("start_clears_error", 32'(load_error), 32'd0);
    chk("cfg_rdy_busy", 32'(cfg_wr_ready), 32'd0);
    while (!tap_if.tap_dout_valid && lat < 12) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 2) chk("flush_enable_low2", 32'(fir_enable), 32'd0);
      if (lat == 3) chk("arm_enable_high", 32'(fir_enable), 32'd1);
    end
    chk("first_valid_latency", 32'(lat), 32'd4);

    cyc       = 0;
    wr_issued = 1'b0;
    while (beats < T && cyc < 400 && !(abort_at > 0 && beats >= abort_at)) begin
      @(posedge clk); #1;
      cyc++;
      if (rdy_mode == 1) tap_if.tap_dout_ready = pat[cyc % 16];
      if (mid_wr && beats >= 5 && !wr_issued) begin
        chk("cfg_rdy_stream", 32'(cfg_wr_ready), 32'd0);
        cfg_wr_addr  = 4'd3;
        cfg_wr_data  = 16'hBEEF;
        cfg_wr_valid = 1'b1;
        wr_issued    = 1'b1;
      end else begin
        cfg_wr_valid = 1'b0;
      end
    end
    cfg_wr_valid = 1'b0;

    if (abort_at > 0) begin
      chk("abort_point", 32'(beats), 32'(abort_at));
      chk_en = 1'b0;
      exp_q.delete();
      reset  = 1'b1;
      @(posedge clk); #1;
      chk("abort_enable", 32'(fir_enable), 32'd0);
      chk("abort_valid", 32'(tap_if.tap_dout_valid), 32'd0);
      chk("abort_dout", 32'(tap_if.tap_dout), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_cfg_rdy", 32'(cfg_wr_ready), 32'd0);
      reset     = 1'b0;
      seen_done = load_done;
      repeat (4) begin
        @(posedge clk); #1;
        seen_done |= load_done;
      end
      chk("abort_no_done", 32'(seen_done), 32'd0);
      return;
    end

    chk("stream_beats", 32'(beats), 32'(T));
    chk("valid_drop_after_last", 32'(tap_if.tap_dout_valid), 32'd0);
    chk("wait_busy", 32'(busy), 32'd1);

    exp_done = (rdy_after >= 0 && rdy_after < TO);
    exp_n    = exp_done ? rdy_after + 1 : TO;
    n        = 0;
    while (busy && n < 200) begin
      if (rdy_after >= 0 && n >= rdy_after) fir_ready_in = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("wait_cycles", 32'(n), 32'(exp_n));
    chk("load_done", 32'(load_done), 32'(exp_done));
    chk("load_error", 32'(load_error), 32'(!exp_done));
    fir_ready_in = 1'b0;
    @(posedge clk); #1;
    chk("done_pulse_clear", 32'(load_done), 32'd0);
    chk("error_sticky", 32'(load_error), 32'(!exp_done));
    chk("fir_enable_kept", 32'(fir_enable), 32'd1);
    chk("cfg_rdy_idle", 32'(cfg_wr_ready), 32'd1);
    chk_en = 1'b0;
  endtask

  initial begin
    reset                 = 1'b1;
    cfg_wr_addr           = '0;
    cfg_wr_data           = '0;
    cfg_wr_valid          = 1'b0;
    load_start            = 1'b0;
    fir_ready_in          = 1'b0;
    tap_if.tap_dout_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fir_enable", 32'(fir_enable), 32'd0);
    chk("rst_valid", 32'(tap_if.tap_dout_valid), 32'd0);
    chk("rst_dout", 32'(tap_if.tap_dout), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(load_done), 32'd0);
    chk("rst_error", 32'(load_error), 32'd0);
    chk("rst_cfg_rdy", 32'(cfg_wr_ready), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("idle_cfg_rdy", 32'(cfg_wr_ready), 32'd1);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int a = 0; a < T; a++) cfg_write(a, a + 1);
    build_exp();
    chk("model_first", 32'(exp_q[0]), 32'h0001);
    chk("model_mid", 32'(exp_q[8]), 32'(MID_TAP));
    chk("model_last", 32'(exp_q[T-1]), 32'(LAST_TAP));

    run_load(0, 2, 0, 1'b0, 1'b0);
    chk("t1_first_beat", 32'(first_dat), 32'h0001);
    chk("t1_last_beat", 32'(last_dat), 32'(LAST_TAP));

    run_load(1, 2, 0, 1'b0, 1'b0);
    run_load(0, -1, 0, 1'b0, 1'b0);
    run_load(0, 5, 0, 1'b0, 1'b0);

    run_load(0, -1, 7, 1'b0, 1'b0);
    run_load(0, 0, 0, 1'b0, 1'b0);
    chk("after_abort_first", 32'(first_dat), 32'h0001);

    run_load(0, 1, 0, 1'b1, 1'b0);
    run_load(1, 3, 0, 1'b0, 1'b0);

    run_load(0, 2, 0, 1'b0, 1'b1);
    chk("same_cycle_write_first", 32'(first_dat), 32'h1234);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
